// File: rtl/rn_axis_pkt_sink.sv
// rn_axis_pkt_sink
// Receive end of a stimulus AXI-Stream. Accepts beats under optional LFSR-driven
// backpressure, counts bytes/beats per packet, checks tkeep and tuser_size
// consistency and queues one descriptor per completed packet in a FWFT FIFO.
module rn_axis_pkt_sink #(
   parameter int          AXIS_DATA_WIDTH = 512,
   parameter int          AXIS_KEEP_WIDTH = 64,
   parameter int          USER_SIZE_WIDTH = 16,
   parameter int          DESC_FIFO_DEPTH = 16,
   parameter logic [15:0] BP_SEED         = 16'hACE1
) (
   input  logic                       axis_clk,
   input  logic                       axis_rst,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   input  logic [USER_SIZE_WIDTH-1:0] s_axis_tuser_size,
   output logic                       s_axis_tready,
   input  logic                       bp_enable,
   input  logic [7:0]                 bp_thresh,
   output logic                       desc_valid,
   input  logic                       desc_ready,
   output logic [USER_SIZE_WIDTH-1:0] desc_len,
   output logic [15:0]                desc_beats,
   output logic [63:0]                desc_hdr,
   output logic [2:0]                 desc_err,
   output logic [63:0]                pkt_cnt,
   output logic [31:0]                err_cnt
);

   localparam int POP_W  = $clog2(AXIS_KEEP_WIDTH + 1);
   localparam int PTR_W  = (DESC_FIFO_DEPTH > 1) ? $clog2(DESC_FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int ACC_W  = USER_SIZE_WIDTH + 1;
   localparam int SUM_W  = ACC_W + 1;
   localparam int DESC_W = USER_SIZE_WIDTH + 16 + 64 + 3;

   typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

   genvar gi;

   // ---------------------------------------------------------------------------
   // Backpressure generator
   // ---------------------------------------------------------------------------
   logic [15:0] lfsr_reg;
   logic        stall_reg;

   // Fibonacci LFSR (taps 16,14,13,11) stepping only while backpressure is on.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         lfsr_reg  <= BP_SEED;
         stall_reg <= 1'b0;
      end else begin
         if (bp_enable)
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
         stall_reg <= bp_enable & (lfsr_reg[7:0] < bp_thresh);
      end
   end

   // ---------------------------------------------------------------------------
   // Ready / accept. The descriptor waiting to be written counts as occupied so
   // a packet can never complete into a full FIFO.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] fifo_cnt_reg;
   logic             push_pend_reg;
   logic [CNT_W-1:0] fifo_occ;
   logic             beat_acc;

   assign fifo_occ      = fifo_cnt_reg + CNT_W'(push_pend_reg);
   assign s_axis_tready = ~axis_rst & ~stall_reg & (fifo_occ != CNT_W'(DESC_FIFO_DEPTH));
   assign beat_acc      = s_axis_tvalid & s_axis_tready;

   // ---------------------------------------------------------------------------
   // tkeep analysis: a "step" is a cleared lane with a set lane right above it,
   // which is exactly what breaks a 2^n-1 pattern.
   // ---------------------------------------------------------------------------
   logic [AXIS_KEEP_WIDTH-2:0] keep_step;
   logic                       keep_full;
   logic                       keep_contig;
   logic [POP_W-1:0]           keep_pop;

   generate
      for (gi = 0; gi < AXIS_KEEP_WIDTH - 1; gi++) begin : g_keep_step
         assign keep_step[gi] = s_axis_tkeep[gi+1] & ~s_axis_tkeep[gi];
      end
   endgenerate

   assign keep_full   = &s_axis_tkeep;
   assign keep_contig = s_axis_tkeep[0] & ~(|keep_step);

   // Number of valid bytes in the current beat.
   always_comb begin
      keep_pop = '0;
      for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
         keep_pop = keep_pop + POP_W'(s_axis_tkeep[i]);
   end

   // ---------------------------------------------------------------------------
   // Packet tracking
   // ---------------------------------------------------------------------------
   state_t                     state_reg, state_next;
   logic [ACC_W-1:0]           bytes_reg, bytes_next;
   logic [15:0]                beats_reg, beats_next;
   logic [USER_SIZE_WIDTH-1:0] ref_sz_reg, ref_sz_next;
   logic [63:0]                hdr_reg, hdr_next;
   logic                       err_keep_reg, err_keep_next;
   logic                       err_size_reg, err_size_next;
   logic                       push_pend_next;
   logic [DESC_W-1:0]          pend_desc_reg, pend_desc_next;

   logic [ACC_W-1:0]           bytes_base, bytes_new;
   logic [SUM_W-1:0]           bytes_sum;
   logic [15:0]                beats_base, beats_new;
   logic [USER_SIZE_WIDTH-1:0] ref_sz_cur, len_new;
   logic [63:0]                hdr_cur;
   logic                       keep_err_new, size_err_new, len_err_new;

   // Running totals as they would stand after the current beat; in IDLE the
   // beat starts a fresh packet, so the stored totals are ignored.
   always_comb begin
      if (state_reg == ST_IDLE) begin
         bytes_base = '0;
         beats_base = '0;
         ref_sz_cur = s_axis_tuser_size;
         hdr_cur    = s_axis_tdata[63:0];
      end else begin
         bytes_base = bytes_reg;
         beats_base = beats_reg;
         ref_sz_cur = ref_sz_reg;
         hdr_cur    = hdr_reg;
      end
      bytes_sum    = {1'b0, bytes_base} + SUM_W'(keep_pop);
      bytes_new    = bytes_sum[ACC_W] ? {ACC_W{1'b1}} : bytes_sum[ACC_W-1:0];
      beats_new    = (beats_base == 16'hFFFF) ? beats_base : beats_base + 16'd1;
      keep_err_new = ((state_reg == ST_IN_PKT) & err_keep_reg) |
                     (s_axis_tlast ? ~keep_contig : ~keep_full);
      size_err_new = (state_reg == ST_IN_PKT) &
                     (err_size_reg | (s_axis_tuser_size != ref_sz_reg));
      len_new      = bytes_new[ACC_W-1] ? {USER_SIZE_WIDTH{1'b1}} : bytes_new[USER_SIZE_WIDTH-1:0];
      len_err_new  = bytes_new[ACC_W-1] | (bytes_new[USER_SIZE_WIDTH-1:0] != ref_sz_cur);
   end

   // Next-state logic: a tlast beat closes the packet and stages its descriptor.
   always_comb begin
      state_next     = state_reg;
      bytes_next     = bytes_reg;
      beats_next     = beats_reg;
      ref_sz_next    = ref_sz_reg;
      hdr_next       = hdr_reg;
      err_keep_next  = err_keep_reg;
      err_size_next  = err_size_reg;
      push_pend_next = 1'b0;
      pend_desc_next = pend_desc_reg;
      if (beat_acc) begin
         if (s_axis_tlast) begin
            state_next     = ST_IDLE;
            push_pend_next = 1'b1;
            pend_desc_next = {len_new, beats_new, hdr_cur, size_err_new, keep_err_new, len_err_new};
         end else begin
            state_next    = ST_IN_PKT;
            bytes_next    = bytes_new;
            beats_next    = beats_new;
            ref_sz_next   = ref_sz_cur;
            hdr_next      = hdr_cur;
            err_keep_next = keep_err_new;
            err_size_next = size_err_new;
         end
      end
   end

   // Tracking registers; reset drops any partial packet and staged descriptor.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state_reg     <= ST_IDLE;
         bytes_reg     <= '0;
         beats_reg     <= '0;
         ref_sz_reg    <= '0;
         hdr_reg       <= '0;
         err_keep_reg  <= 1'b0;
         err_size_reg  <= 1'b0;
         push_pend_reg <= 1'b0;
         pend_desc_reg <= '0;
      end else begin
         state_reg     <= state_next;
         bytes_reg     <= bytes_next;
         beats_reg     <= beats_next;
         ref_sz_reg    <= ref_sz_next;
         hdr_reg       <= hdr_next;
         err_keep_reg  <= err_keep_next;
         err_size_reg  <= err_size_next;
         push_pend_reg <= push_pend_next;
         pend_desc_reg <= pend_desc_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Descriptor FIFO (first-word-fall-through). Kept as a small asynchronously
   // read array so the head entry is visible in the same cycle it is written.
   // ---------------------------------------------------------------------------
   logic [DESC_W-1:0] fifo_mem [0:DESC_FIFO_DEPTH-1];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic              fifo_push, fifo_pop;
   logic [63:0]       pkt_cnt_reg;
   logic [31:0]       err_cnt_reg;

   assign fifo_push  = push_pend_reg;
   assign desc_valid = (fifo_cnt_reg != '0);
   assign fifo_pop   = desc_valid & desc_ready;

   // Storage array write port.
   always_ff @(posedge axis_clk) begin
      if (fifo_push)
         fifo_mem[wr_ptr_reg] <= pend_desc_reg;
   end

   // Pointers, occupancy and statistics counters.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
         pkt_cnt_reg  <= '0;
         err_cnt_reg  <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
            pkt_cnt_reg <= pkt_cnt_reg + 64'd1;
            if (|pend_desc_reg[2:0])
               err_cnt_reg <= err_cnt_reg + 32'd1;
         end
         if (fifo_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
            2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
            default: fifo_cnt_reg <= fifo_cnt_reg;
         endcase
      end
   end

   assign {desc_len, desc_beats, desc_hdr, desc_err} = fifo_mem[rd_ptr_reg];
   assign pkt_cnt = pkt_cnt_reg;
   assign err_cnt = err_cnt_reg;

   // Only the first 64 data bits are ever captured.
   logic unused_tdata;
   assign unused_tdata = ^s_axis_tdata[AXIS_DATA_WIDTH-1:64];

endmodule

// File: tb/tb_rn_axis_pkt_sink.sv
// tb_rn_axis_pkt_sink
// Directed bench for the AXI-Stream packet sink: single and multi-beat packets,
// each error flag, length saturation, FIFO full holding, backpressure with
// random lengths and reset in the middle of a packet.
module tb_rn_axis_pkt_sink;

   logic         axis_clk = 1'b0;
   logic         axis_rst;
   logic [511:0] s_axis_tdata;
   logic [63:0]  s_axis_tkeep;
   logic         s_axis_tvalid;
   logic         s_axis_tlast;
   logic [15:0]  s_axis_tuser_size;
   logic         s_axis_tready;
   logic         bp_enable;
   logic [7:0]   bp_thresh;
   logic         desc_valid;
   logic         desc_ready;
   logic [15:0]  desc_len;
   logic [15:0]  desc_beats;
   logic [63:0]  desc_hdr;
   logic [2:0]   desc_err;
   logic [63:0]  pkt_cnt;
   logic [31:0]  err_cnt;

   int checks   = 0;
   int failures = 0;
   int toggles  = 0;
   logic prev_ready = 1'b0;

   localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   always #5 axis_clk = ~axis_clk;

   rn_axis_pkt_sink dut (
      .axis_clk          (axis_clk),
      .axis_rst          (axis_rst),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tkeep      (s_axis_tkeep),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tlast      (s_axis_tlast),
      .s_axis_tuser_size (s_axis_tuser_size),
      .s_axis_tready     (s_axis_tready),
      .bp_enable         (bp_enable),
      .bp_thresh         (bp_thresh),
      .desc_valid        (desc_valid),
      .desc_ready        (desc_ready),
      .desc_len          (desc_len),
      .desc_beats        (desc_beats),
      .desc_hdr          (desc_hdr),
      .desc_err          (desc_err),
      .pkt_cnt           (pkt_cnt),
      .err_cnt           (err_cnt)
   );

   // Count tready transitions seen between clock edges.
   always @(negedge axis_clk) begin
      if (s_axis_tready !== prev_ready) toggles++;
      prev_ready = s_axis_tready;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one beat and hold it until accepted; returns on the negedge after acceptance.
   task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic last,
                             input logic [15:0] tsz);
      int  n;
      bit  took;
      s_axis_tdata      = d;
      s_axis_tkeep      = k;
      s_axis_tlast      = last;
      s_axis_tuser_size = tsz;
      s_axis_tvalid     = 1'b1;
      #1;
      n = 0;
      forever begin
         took = s_axis_tready;
         @(posedge axis_clk);
         @(negedge axis_clk);
         if (took) break;
         n++;
         if (n > 2000) begin
            chk("beat_timeout", 64'd0, 64'd1);
            break;
         end
      end
   endtask

   // mode bit0: first beat tkeep=0x0F; mode bit1: later beats carry tsz+1.
   task automatic send_pkt(input int nbeats, input logic [63:0] last_keep, input int tsz,
                           input int mode, input logic [63:0] hdr);
      for (int b = 0; b < nbeats; b++) begin
         logic [63:0]  k;
         logic [15:0]  t;
         logic [511:0] d;
         k = (b == nbeats - 1) ? last_keep : KEEP_ALL;
         if (b == 0 && (mode & 1) != 0 && nbeats > 1) k = 64'h0F;
         t = 16'(tsz);
         if (b > 0 && (mode & 2) != 0) t = 16'(tsz + 1);
         d = {8{hdr ^ 64'(b)}};
         drive_beat(d, k, (b == nbeats - 1), t);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic pop_desc(input string tag, input logic [15:0] len, input logic [15:0] beats,
                           input logic [63:0] hdr, input logic [2:0] err);
      int n = 0;
      while (!desc_valid && n < 2000) begin
         @(negedge axis_clk);
         n++;
      end
      chk({tag, "_valid"}, 64'(desc_valid), 64'd1);
      chk({tag, "_len"},   64'(desc_len),   64'(len));
      chk({tag, "_beats"}, 64'(desc_beats), 64'(beats));
      chk({tag, "_hdr"},   desc_hdr,        hdr);
      chk({tag, "_err"},   64'(desc_err),   64'(err));
      $display("desc %s len=%0d beats=%0d hdr=%0h err=%b", tag, desc_len, desc_beats, desc_hdr, desc_err);
      desc_ready = 1'b1;
      @(posedge axis_clk);
      @(negedge axis_clk);
      desc_ready = 1'b0;
   endtask

   function automatic logic [63:0] last_keep_of(input int len);
      logic [63:0] one;
      int          r;
      one = 64'd1;
      r   = len % 64;
      return (r == 0) ? KEEP_ALL : ((one << r) - 64'd1);
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int          t6_start;
      int          q_len[$];
      int          q_beats[$];
      logic [63:0] q_hdr[$];
      int          got6;

      axis_rst          = 1'b1;
      s_axis_tdata      = '0;
      s_axis_tkeep      = '0;
      s_axis_tvalid     = 1'b0;
      s_axis_tlast      = 1'b0;
      s_axis_tuser_size = '0;
      bp_enable         = 1'b0;
      bp_thresh         = 8'd0;
      desc_ready        = 1'b0;

      // Reset state
      repeat (3) @(negedge axis_clk);
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_valid",  64'(desc_valid),    64'd0);
      chk("rst_pkt",    pkt_cnt,            64'd0);
      chk("rst_err",    64'(err_cnt),       64'd0);
      axis_rst = 1'b0;
      #1;
      chk("post_rst_tready", 64'(s_axis_tready), 64'd1);

      // T1: single 64B beat, one-cycle descriptor latency
      send_pkt(1, KEEP_ALL, 64, 0, 64'h1111_2222_3333_4444);
      chk("t1_lat_valid", 64'(desc_valid), 64'd0);
      chk("t1_lat_pkt",   pkt_cnt,         64'd0);
      @(negedge axis_clk);
      chk("t1_valid_now", 64'(desc_valid), 64'd1);
      chk("t1_pkt",       pkt_cnt,         64'd1);
      pop_desc("t1", 16'd64, 16'd1, 64'h1111_2222_3333_4444, 3'b000);

      // T2: 130B in 3 beats
      send_pkt(3, 64'h3, 130, 0, 64'hA000_0000_0000_0002);
      pop_desc("t2", 16'd130, 16'd3, 64'hA000_0000_0000_0002, 3'b000);

      // T3: length mismatch
      send_pkt(3, 64'h3, 100, 0, 64'hA000_0000_0000_0003);
      pop_desc("t3", 16'd130, 16'd3, 64'hA000_0000_0000_0003, 3'b001);
      chk("t3_errcnt", 64'(err_cnt), 64'd1);

      // T4: tkeep and tuser_size errors, length saturation
      send_pkt(2, KEEP_ALL, 68, 1, 64'hB000_0000_0000_0001);
      pop_desc("t4_keep_mid", 16'd68, 16'd2, 64'hB000_0000_0000_0001, 3'b010);
      send_pkt(3, 64'h3, 130, 2, 64'hB000_0000_0000_0002);
      pop_desc("t4_size_chg", 16'd130, 16'd3, 64'hB000_0000_0000_0002, 3'b100);
      send_pkt(2, 64'h5, 66, 0, 64'hB000_0000_0000_0003);
      pop_desc("t4_keep_gap", 16'd66, 16'd2, 64'hB000_0000_0000_0003, 3'b010);
      send_pkt(2, 64'h0, 64, 0, 64'hB000_0000_0000_0004);
      pop_desc("t4_keep_zero", 16'd64, 16'd2, 64'hB000_0000_0000_0004, 3'b010);
      send_pkt(1025, KEEP_ALL, 65535, 0, 64'hB000_0000_0000_0005);
      pop_desc("t4_sat", 16'hFFFF, 16'd1025, 64'hB000_0000_0000_0005, 3'b001);
      chk("t4_errcnt", 64'(err_cnt), 64'd6);
      chk("t4_pktcnt", pkt_cnt,      64'd8);

      // T5: fill the FIFO back-to-back, 17th packet must be held
      for (int i = 0; i < 16; i++)
         send_pkt(1, KEEP_ALL, 64, 0, 64'h500 + 64'(i));
      s_axis_tdata      = {8{64'h510}};
      s_axis_tkeep      = KEEP_ALL;
      s_axis_tlast      = 1'b1;
      s_axis_tuser_size = 16'd64;
      s_axis_tvalid     = 1'b1;
      repeat (5) @(negedge axis_clk);
      chk("t5_held",   64'(s_axis_tready), 64'd0);
      chk("t5_pktcnt", pkt_cnt,            64'd24);
      pop_desc("t5_0", 16'd64, 16'd1, 64'h500, 3'b000);
      drive_beat({8{64'h510}}, KEEP_ALL, 1'b1, 16'd64);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      for (int i = 1; i <= 16; i++)
         pop_desc($sformatf("t5_%0d", i), 16'd64, 16'd1, 64'h500 + 64'(i), 3'b000);
      chk("t5_pktcnt_end", pkt_cnt,      64'd25);
      chk("t5_errcnt_end", 64'(err_cnt), 64'd6);

      // T6: random lengths under backpressure, popped as they arrive
      bp_enable  = 1'b1;
      bp_thresh  = 8'd128;
      desc_ready = 1'b1;
      t6_start   = toggles;
      got6       = 0;
      fork
         begin
            for (int i = 0; i < 50; i++) begin
               int len;
               len = int'($urandom_range(1, 300));
               q_len.push_back(len);
               q_beats.push_back((len + 63) / 64);
               q_hdr.push_back(64'h600 + 64'(i));
               send_pkt((len + 63) / 64, last_keep_of(len), len, 0, 64'h600 + 64'(i));
            end
         end
         begin
            int cyc = 0;
            while (got6 < 50 && cyc < 20000) begin
               @(negedge axis_clk);
               cyc++;
               if (desc_valid) begin
                  if (q_len.size() == 0) begin
                     chk("t6_unexpected", 64'd1, 64'd0);
                  end else begin
                     int          el, eb;
                     logic [63:0] eh;
                     el = q_len.pop_front();
                     eb = q_beats.pop_front();
                     eh = q_hdr.pop_front();
                     chk("t6_len",   64'(desc_len),   64'(el));
                     chk("t6_beats", 64'(desc_beats), 64'(eb));
                     chk("t6_hdr",   desc_hdr,        eh);
                     chk("t6_err",   64'(desc_err),   64'd0);
                     $display("desc t6_%0d len=%0d beats=%0d err=%b", got6, desc_len, desc_beats, desc_err);
                  end
                  got6++;
               end
            end
            chk("t6_count", 64'(got6), 64'd50);
         end
      join
      desc_ready = 1'b0;
      chk("t6_toggled", 64'((toggles - t6_start) > 10), 64'd1);

      // T6 tail: reset mid-packet, then one clean packet
      drive_beat({8{64'h700}}, KEEP_ALL, 1'b0, 16'd192);
      s_axis_tvalid = 1'b0;
      axis_rst      = 1'b1;
      #1;
      chk("t6_rst_tready", 64'(s_axis_tready), 64'd0);
      repeat (2) @(negedge axis_clk);
      axis_rst = 1'b0;
      repeat (3) @(negedge axis_clk);
      chk("t6_rst_valid", 64'(desc_valid), 64'd0);
      chk("t6_rst_pkt",   pkt_cnt,         64'd0);
      chk("t6_rst_err",   64'(err_cnt),    64'd0);
      send_pkt(2, last_keep_of(100), 100, 0, 64'h800);
      pop_desc("t6_clean", 16'd100, 16'd2, 64'h800, 3'b000);
      chk("t6_clean_pkt", pkt_cnt, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
